// File: rtl/timer_bank.sv
// Bank of independent down-counters sharing one free-running prescaler.
// Each channel is one-shot or auto-reload, can be aborted, and flags busy/expired.
module timer_bank #(
  parameter int WIDTH          = 16,
  parameter int CHANNELS       = 4,
  parameter int PRESCALE_WIDTH = 8,
  parameter int CH_BITS        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load,
  input  logic [CH_BITS-1:0]        load_ch,
  input  logic [WIDTH-1:0]          load_value,
  input  logic                      load_periodic,
  input  logic [CHANNELS-1:0]       stop,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic [CHANNELS-1:0]       busy,
  output logic [CHANNELS-1:0]       expired,
  output logic                      any_busy
);

  // Floors at zero so a count can never wrap to all-ones.
  function automatic logic [WIDTH-1:0] dec_floor(input logic [WIDTH-1:0] v);
    return (v == '0) ? '0 : v - WIDTH'(1);
  endfunction

  logic [PRESCALE_WIDTH-1:0] pre_cnt;
  logic                      tick;

  // >= rather than == so lowering prescale below pre_cnt still ticks promptly.
  assign tick = (pre_cnt >= prescale);

  always_ff @(posedge clk) begin
    if (reset)     pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else           pre_cnt <= pre_cnt + PRESCALE_WIDTH'(1);
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] reload;
    logic             periodic;
    logic             exp_q;
    logic             sel;

    // Out-of-range load_ch values never match any channel index.
    assign sel = load && (load_ch == CH_BITS'(i));

    always_ff @(posedge clk) begin
      if (reset) begin
        count    <= '0;
        reload   <= '0;
        periodic <= 1'b0;
        exp_q    <= 1'b0;
      end else if (sel) begin
        count    <= load_value;
        reload   <= load_value;
        periodic <= load_periodic;
        exp_q    <= 1'b0;
      end else if (stop[i]) begin
        count <= '0;
        exp_q <= 1'b0;
      end else if (tick && (count == WIDTH'(1))) begin
        count <= periodic ? reload : '0;
        exp_q <= 1'b1;
      end else if (tick && (count > WIDTH'(1))) begin
        count <= dec_floor(count);
        exp_q <= 1'b0;
      end else begin
        exp_q <= 1'b0;
      end
    end

    assign busy[i]    = (count != '0);
    assign expired[i] = exp_q;
  end

  assign any_busy = |busy;

endmodule

// File: tb/tb_timer_bank.sv
// Bench for timer_bank (3-channel build): directed scenarios with literal
// expectations plus a long randomized run against a behavioural model.
module tb_timer_bank;
  localparam int W  = 8;
  localparam int CH = 3;
  localparam int PW = 4;
  localparam int CB = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          load = 1'b0;
  logic [CB-1:0] load_ch = '0;
  logic [W-1:0]  load_value = '0;
  logic          load_periodic = 1'b0;
  logic [CH-1:0] stop = '0;
  logic [PW-1:0] prescale = '0;
  logic [CH-1:0] busy;
  logic [CH-1:0] expired;
  logic          any_busy;

  int checks = 0;
  int fails  = 0;
  bit chk_en = 1'b0;

  timer_bank #(.WIDTH(W), .CHANNELS(CH), .PRESCALE_WIDTH(PW), .CH_BITS(CB)) dut (
    .clk(clk), .reset(reset), .load(load), .load_ch(load_ch),
    .load_value(load_value), .load_periodic(load_periodic), .stop(stop),
    .prescale(prescale), .busy(busy), .expired(expired), .any_busy(any_busy)
  );

  always #5 clk = ~clk;

  // Reference model: remaining ticks per channel, stepped once per clock edge.
  int m_cnt [CH];
  int m_rel [CH];
  bit m_per [CH];
  bit m_exp [CH];
  int m_pre = 0;

  always @(posedge clk) begin
    bit t;
    t = (m_pre >= int'(prescale));
    for (int i = 0; i < CH; i++) begin
      if (reset) begin
        m_cnt[i] = 0; m_rel[i] = 0; m_per[i] = 0; m_exp[i] = 0;
      end else if (load && int'(load_ch) == i) begin
        m_cnt[i] = int'(load_value); m_rel[i] = int'(load_value);
        m_per[i] = load_periodic; m_exp[i] = 0;
      end else if (stop[i]) begin
        m_cnt[i] = 0; m_exp[i] = 0;
      end else if (t && m_cnt[i] == 1) begin
        m_exp[i] = 1; m_cnt[i] = m_per[i] ? m_rel[i] : 0;
      end else begin
        m_exp[i] = 0;
        if (t && m_cnt[i] > 1) m_cnt[i] = m_cnt[i] - 1;
      end
    end
    m_pre = reset ? 0 : (t ? 0 : m_pre + 1);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      logic [CH-1:0] mb, me;
      for (int i = 0; i < CH; i++) begin
        mb[i] = (m_cnt[i] != 0);
        me[i] = m_exp[i];
      end
      check("model_busy", 32'(busy), 32'(mb));
      check("model_expired", 32'(expired), 32'(me));
      check("model_any_busy", 32'(any_busy), 32'(|mb));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; step(); step(); reset = 1'b0;
  endtask

  task automatic do_load(input int ch, input int v, input bit per);
    load = 1'b1; load_ch = CB'(ch); load_value = W'(v); load_periodic = per;
    step();
    load = 1'b0;
  endtask

  initial begin
    int blen, npul;
    bit flag;
    do_reset();
    chk_en = 1'b1;
    check("reset_busy", 32'(busy), 0);
    check("reset_expired", 32'(expired), 0);
    check("reset_any_busy", 32'(any_busy), 0);

    // One-shot V=3, prescale 0
    prescale = '0;
    do_load(0, 3, 1'b0);
    blen = 0; npul = 0; flag = 0;
    for (int k = 0; k < 6; k++) begin
      blen += busy[0]; npul += expired[0];
      if (expired[0] && busy[0]) flag = 1;
      if (busy[2:1] != 0 || expired[2:1] != 0) flag = 1;
      step();
    end
    check("oneshot_busy_len", blen, 3);
    check("oneshot_pulses", npul, 1);
    check("oneshot_other_idle", flag, 0);

    // Periodic V=4 on ch2
    do_reset();
    do_load(2, 4, 1'b1);
    blen = 0; npul = 0;
    for (int k = 0; k < 13; k++) begin
      blen += busy[2]; npul += expired[2];
      step();
    end
    check("periodic_pulses", npul, 3);
    check("periodic_busy_len", blen, 13);
    stop = 3'b100; step(); stop = '0;
    check("stop_busy", busy[2], 0);
    check("stop_no_pulse", expired[2], 0);

    // Periodic V=1: expired every cycle from N+2
    do_reset();
    do_load(0, 1, 1'b1);
    check("per1_first", expired[0], 0);
    step();
    npul = 0;
    for (int k = 0; k < 5; k++) begin npul += expired[0]; step(); end
    check("per1_pulses", npul, 5);

    // Prescale 2, V=2 on ch1
    do_reset();
    prescale = 4'd2;
    do_load(1, 2, 1'b0);
    blen = 0; npul = 0;
    for (int k = 0; k < 12; k++) begin
      blen += busy[1]; npul += expired[1];
      step();
    end
    check("pre2_busy_in_range", (blen >= 4 && blen <= 6), 1);
    check("pre2_pulses", npul, 1);

    // Load and stop together: load wins
    do_reset();
    prescale = '0;
    stop = 3'b001;
    do_load(0, 5, 1'b0);
    stop = '0;
    blen = 0;
    for (int k = 0; k < 8; k++) begin blen += busy[0]; step(); end
    check("load_beats_stop_len", blen, 5);

    // Reset mid-count
    do_reset();
    do_load(2, 2, 1'b0);
    reset = 1'b1; step(); reset = 1'b0;
    check("midreset_busy", 32'(busy), 0);
    check("midreset_expired", 32'(expired), 0);
    check("midreset_any", 32'(any_busy), 0);

    // Out-of-range channel and zero load value are no-ops
    do_reset();
    flag = 0;
    do_load(3, 5, 1'b0);
    for (int k = 0; k < 3; k++) begin
      if (busy != 0 || expired != 0) flag = 1;
      step();
    end
    do_load(1, 0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      if (busy != 0 || expired != 0) flag = 1;
      step();
    end
    check("noop_loads", flag, 0);

    // Max load value is legal
    do_load(2, 255, 1'b0);
    blen = 0;
    for (int k = 0; k < 260; k++) begin blen += busy[2]; step(); end
    check("max_value_len", blen, 255);

    // Randomized run
    for (int k = 0; k < 4000; k++) begin
      int r;
      reset = ($urandom_range(0, 299) == 0);
      load = ($urandom_range(0, 5) == 0);
      load_ch = CB'($urandom_range(0, 3));
      r = $urandom_range(0, 19);
      load_value = (r < 2) ? W'(0) : (r == 19) ? W'(255) : W'($urandom_range(1, 7));
      load_periodic = $urandom_range(0, 1);
      stop = ($urandom_range(0, 11) == 0) ? CH'($urandom_range(0, 7)) : '0;
      if ($urandom_range(0, 49) == 0) prescale = PW'($urandom_range(0, 3));
      step();
    end
    load = 1'b0; stop = '0; reset = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
